// File: rtl/missile_pool.sv
// Pool of vertically moving missiles: slot allocation on fire, frame cooldown,
// per-frame movement, exit/collision retirement and a registered draw request.
module missile_pool #(
    parameter int unsigned           SHOT_AMOUNT       = 7,
    parameter int unsigned           RGB_WIDTH         = 8,
    parameter logic [RGB_WIDTH-1:0]  MISSILE_COLOR     = 8'h1F,
    parameter int unsigned           COOLDOWN_WIDTH    = 4,
    parameter int unsigned           SHOOTING_COOLDOWN = 15,
    parameter bit                    DIRECTION_UP      = 1'b1,
    parameter int unsigned           SPEED             = 4,
    parameter int unsigned           MISSILE_W         = 2,
    parameter int unsigned           MISSILE_H         = 5,
    parameter logic [10:0]           SPAWN_OFFSET_X    = 11'd0,
    parameter logic [10:0]           SPAWN_OFFSET_Y    = 11'd0,
    parameter int unsigned           SCREEN_TOP        = 0,
    parameter int unsigned           SCREEN_BOTTOM     = 479,
    localparam int unsigned          CNT_W             = $clog2(SHOT_AMOUNT + 1)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 shooting_pulse,
    input  logic                 startOfFrame,
    input  logic                 collision,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic [10:0]          shooter_X,
    input  logic [10:0]          shooter_Y,
    output logic                 missileDR,
    output logic [RGB_WIDTH-1:0] missileRGB,
    output logic                 shot_fired,
    output logic [CNT_W-1:0]     active_count
);

    localparam logic [11:0] W12      = 12'(MISSILE_W);
    localparam logic [11:0] H12      = 12'(MISSILE_H);
    localparam logic [11:0] SPEED12  = 12'(SPEED);
    localparam logic [10:0] SPEED11  = 11'(SPEED);
    localparam logic [11:0] TOP12    = 12'(SCREEN_TOP);
    localparam logic [11:0] BOTTOM12 = 12'(SCREEN_BOTTOM);

    typedef enum logic {SlotIdle, SlotFlying} slot_state_e;

    slot_state_e                state_q [SHOT_AMOUNT];
    slot_state_e                state_d [SHOT_AMOUNT];
    logic [10:0]                x_q [SHOT_AMOUNT];
    logic [10:0]                x_d [SHOT_AMOUNT];
    logic [10:0]                y_q [SHOT_AMOUNT];
    logic [10:0]                y_d [SHOT_AMOUNT];
    logic [SHOT_AMOUNT-1:0]     hit, hit_q, alloc;
    logic [COOLDOWN_WIDTH-1:0]  cooldown_q, cooldown_d;
    logic                       shot_fired_q;
    logic [CNT_W-1:0]           active_count_q, live_count;
    logic                       any_idle, accept;

    // One-hot pick of the lowest-index idle slot.
    always_comb begin
        alloc    = '0;
        any_idle = 1'b0;
        for (int i = 0; i < SHOT_AMOUNT; i++) begin
            if (state_q[i] == SlotIdle && !any_idle) begin
                alloc[i] = 1'b1;
                any_idle = 1'b1;
            end
        end
    end

    assign accept = shooting_pulse && (cooldown_q == '0) && any_idle;

    // 12-bit compares keep the far edge of a missile near 2047 from wrapping.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SHOT_AMOUNT; i++) begin
            hit[i] = (state_q[i] == SlotFlying)
                  && ({1'b0, pixelX} >= {1'b0, x_q[i]})
                  && ({1'b0, pixelX} <  {1'b0, x_q[i]} + W12)
                  && ({1'b0, pixelY} >= {1'b0, y_q[i]})
                  && ({1'b0, pixelY} <  {1'b0, y_q[i]} + H12);
        end
    end

    always_comb begin
        live_count = '0;
        for (int i = 0; i < SHOT_AMOUNT; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            if (state_q[i] == SlotFlying) begin
                live_count = live_count + CNT_W'(1);
                if (collision && hit_q[i]) begin
                    state_d[i] = SlotIdle;
                end else if (startOfFrame) begin
                    if (DIRECTION_UP) begin
                        if ({1'b0, y_q[i]} < TOP12 + SPEED12) state_d[i] = SlotIdle;
                        else                                   y_d[i] = y_q[i] - SPEED11;
                    end else begin
                        if ({1'b0, y_q[i]} + SPEED12 > BOTTOM12) state_d[i] = SlotIdle;
                        else                                      y_d[i] = y_q[i] + SPEED11;
                    end
                end
            end else if (accept && alloc[i]) begin
                state_d[i] = SlotFlying;
                x_d[i]     = shooter_X + SPAWN_OFFSET_X;
                y_d[i]     = shooter_Y + SPAWN_OFFSET_Y;
            end
        end
    end

    always_comb begin
        cooldown_d = cooldown_q;
        if (accept) begin
            cooldown_d = COOLDOWN_WIDTH'(SHOOTING_COOLDOWN);
        end else if (startOfFrame && cooldown_q != '0) begin
            cooldown_d = cooldown_q - COOLDOWN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < SHOT_AMOUNT; i++) begin
                state_q[i] <= SlotIdle;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
            hit_q          <= '0;
            cooldown_q     <= '0;
            shot_fired_q   <= 1'b0;
            active_count_q <= '0;
        end else begin
            for (int i = 0; i < SHOT_AMOUNT; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            hit_q          <= hit;
            cooldown_q     <= cooldown_d;
            shot_fired_q   <= accept;
            active_count_q <= live_count;
        end
    end

    assign missileDR    = |hit_q;
    assign missileRGB   = MISSILE_COLOR;
    assign shot_fired   = shot_fired_q;
    assign active_count = active_count_q;

endmodule

// File: doc/missile_pool.md
# missile_pool

Parametrised pool of vertically moving missiles for player or enemy fire. It allocates free slots on fire requests, enforces a per-frame cooldown, and moves every live missile once per frame. It retires missiles on screen exit or collision and produces a single registered draw request plus colour for the video mux. One instance sits beside each shooter: the player ship uses upward fire, enemy groups use downward fire.

## Interface
- SHOT_AMOUNT, 7: number of missile slots (1..16)
- RGB_WIDTH, 8: colour width
- MISSILE_COLOR, 8'h1F: constant missile colour
- COOLDOWN_WIDTH, 4: cooldown counter width
- SHOOTING_COOLDOWN, 15: frames between accepted shots; 0 disables cooldown
- DIRECTION_UP, 1: 1 = Y decreases each frame, 0 = Y increases
- SPEED, 4: pixels moved per frame (1..15)
- MISSILE_W, 2 / MISSILE_H, 5: missile size in pixels
- SPAWN_OFFSET_X, 0 / SPAWN_OFFSET_Y, 0: spawn position relative to shooter (11-bit unsigned, added modulo 2^11)
- SCREEN_TOP, 0 / SCREEN_BOTTOM, 479: vertical retire bounds
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- shooting_pulse  in  1  single-cycle fire request
- startOfFrame  in  1  single-cycle frame strobe
- collision  in  1  collision detector hit for the current pixel (pixel is drawn by this block and the target)
- pixelX, pixelY  in  11 each  current scan pixel
- shooter_X, shooter_Y  in  11 each  shooter top-left
- missileDR  out  1  registered draw request
- missileRGB  out  RGB_WIDTH  always MISSILE_COLOR
- shot_fired  out  1  one-cycle pulse when a fire request is accepted
- active_count  out  $clog2(SHOT_AMOUNT+1)  number of live slots, registered

## Operation
- Each slot has states IDLE and FLYING, plus X/Y registers (11-bit).
- **Fire acceptance:** a request is accepted only when all three hold:
  - shooting_pulse=1
  - cooldown==0
  - at least one slot is IDLE
- Otherwise the request is dropped silently, with no queuing.
- The accepted request claims the lowest-index IDLE slot. The slot loads X=shooter_X+SPAWN_OFFSET_X and Y=shooter_Y+SPAWN_OFFSET_Y, then goes to FLYING.
- **Cooldown:** on accept, cooldown loads SHOOTING_COOLDOWN. Otherwise it decrements by 1 on each startOfFrame while nonzero.
- **Movement:** on startOfFrame, each FLYING slot moves by SPEED.
  - Up: if Y < SCREEN_TOP+SPEED, the slot goes IDLE; else Y -= SPEED.
  - Down: if Y+SPEED > SCREEN_BOTTOM (12-bit compare), the slot goes IDLE; else Y += SPEED.
- **Hit test (combinational, per slot):** hit_i = FLYING_i && X_i ≤ pixelX < X_i+MISSILE_W && Y_i ≤ pixelY < Y_i+MISSILE_H. Compares use 12-bit sums so bounds near 2047 do not wrap.
- **Registered outputs:**
  - hit_q_i is hit_i registered.
  - missileDR = OR of hit_q.
- **Collision:** collision && hit_q_i moves slot i to IDLE on the next edge. Every slot with hit_q_i=1 retires; overlapping missiles all die.
- **Priority within one cycle, per slot:** collision retire > frame move/retire.
  - A slot that is IDLE at the edge may be allocated by fire in the same cycle, even if other slots move.
  - A slot allocated in a startOfFrame cycle does not move in that frame.
  - Cooldown load takes precedence over decrement.
- **Reset:** all slots IDLE, X/Y=0, cooldown=0, hit_q=0, missileDR=0, shot_fired=0, active_count=0.
  - Reset mid-flight kills all missiles immediately.

## Timing
- **Fire:** shooting_pulse sampled at edge N.
  - Slot FLYING and shot_fired=1 after edge N.
  - active_count updates after edge N+1.
- **Draw:** pixel (x,y) presented at edge N gives missileDR for that pixel after edge N, i.e. one-cycle latency, aligned with other registered drawers.
- **Collision:** collision asserted in the cycle missileDR=1 means the slot is IDLE after the next edge. Its hit_q clears one edge later.
- **Movement:** new Y is visible after the startOfFrame edge. Pixels of the new frame use the new position.
- Max fire rate is one accepted shot per SHOOTING_COOLDOWN+1 frames. With SHOOTING_COOLDOWN=0, the rate is one per cycle, until the pool is full.

## Test plan
- **Single fire, up:** reset; shooter=(100,400), offsets 0, SPEED=4, one pulse.
  - shot_fired pulse; slot0 at (100,400).
  - After 3 frames Y=388.
  - missileDR=1 one cycle after pixel (101,392) is presented; 0 for (102,388).
- **Cooldown:** two pulses 1 cycle apart, then a pulse every frame.
  - Second pulse is dropped.
  - Next accept occurs on the first pulse after 15 startOfFrame strobes.
  - active_count=1 and then 2.
- **Pool full (SHOOTING_COOLDOWN=0):** 8 pulses.
  - Slots 0..6 fill; 8th pulse is dropped and shot_fired stays 0.
  - Retire slot 2 via collision; the next pulse reuses slot 2.
- **Exit bounds:** up with Y=3, SPEED=4 → IDLE at next frame. Down with Y=476, SCREEN_BOTTOM=479 → IDLE.
- **Simultaneous events:**
  - collision and startOfFrame in the same cycle on slot0 → slot0 IDLE and not moved.
  - fire and startOfFrame in the same cycle → new slot Y equals the spawn Y for the whole frame.
- **Async reset mid-flight:** 3 missiles flying; resetN low for 1 cycle mid-frame → all outputs 0 immediately, active_count=0, next pulse accepted at once.
